// File: rtl/cve2_ex_result_sequencer.sv
// Issues operations to multi-cycle functional units and retires their results
// strictly in issue order through a small completion buffer, with flush support.
module cve2_ex_result_sequencer #(
  parameter int NumUnits    = 3,
  parameter int DataWidth   = 32,
  parameter int Depth       = 4,
  parameter int TagWidth    = 5,
  parameter int StatusWidth = 5,
  localparam int UnitW = (NumUnits > 1) ? $clog2(NumUnits) : 1,
  localparam int PtrW  = $clog2(Depth),
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [UnitW-1:0]                issue_unit_i,
  input  logic [TagWidth-1:0]             issue_rd_i,
  input  logic                            flush_i,
  output logic [NumUnits-1:0]             unit_in_valid_o,
  input  logic [NumUnits-1:0]             unit_in_ready_i,
  input  logic [NumUnits-1:0]             unit_out_valid_i,
  output logic [NumUnits-1:0]             unit_out_ready_o,
  input  logic [NumUnits*DataWidth-1:0]   unit_result_i,
  input  logic [NumUnits*StatusWidth-1:0] unit_status_i,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic [TagWidth-1:0]             wb_rd_o,
  output logic [DataWidth-1:0]            wb_data_o,
  output logic [StatusWidth-1:0]          wb_status_o,
  output logic                            busy_o,
  output logic [CntW-1:0]                 outstanding_o
);

  logic [PtrW:0]            head_r;
  logic [PtrW:0]            tail_r;
  logic                     done_r   [Depth];
  logic [UnitW-1:0]         unit_r   [Depth];
  logic [TagWidth-1:0]      rd_r     [Depth];
  logic [DataWidth-1:0]     data_r   [Depth];
  logic [StatusWidth-1:0]   status_r [Depth];
  logic [CntW-1:0]          drop_cnt_r [NumUnits];

  logic [PtrW-1:0]          head_idx_s;
  logic [PtrW-1:0]          tail_idx_s;
  logic [CntW-1:0]          count_s;
  logic                     full_s;
  logic                     issue_ok_s;
  logic                     sel_ready_s;
  logic                     accept_s;
  logic                     wb_fire_s;
  logic [PtrW:0]            head_next_s;
  logic [PtrW:0]            tail_next_s;
  logic [NumUnits-1:0]      pend_s;
  logic [NumUnits-1:0]      drop_nz_s;
  logic [NumUnits-1:0]      cap_s;
  logic [NumUnits-1:0]      drop_s;
  logic [PtrW-1:0]          target_s    [NumUnits];
  logic [CntW-1:0]          undone_cnt_s [NumUnits];
  logic [CntW-1:0]          flush_add_s  [NumUnits];

  assign head_idx_s = head_r[PtrW-1:0];
  assign tail_idx_s = tail_r[PtrW-1:0];
  assign count_s    = CntW'(tail_r - head_r);
  assign full_s     = (count_s == CntW'(Depth));
  assign issue_ok_s = ({1'b0, issue_unit_i} < (UnitW + 1)'(NumUnits));

  assign issue_ready_o = ~full_s & ~flush_i & issue_ok_s & sel_ready_s;
  assign accept_s      = issue_valid_i & issue_ready_o;

  assign wb_valid_o    = (count_s != '0) & done_r[head_idx_s];
  assign wb_rd_o       = rd_r[head_idx_s];
  assign wb_data_o     = data_r[head_idx_s];
  assign wb_status_o   = status_r[head_idx_s];
  assign wb_fire_s     = wb_valid_o & wb_ready_i;
  assign outstanding_o = count_s;
  assign busy_o        = (count_s != '0) | (|drop_nz_s);

  // A flush keeps only an entry retiring this cycle, so tail collapses onto the new head.
  assign head_next_s = head_r + (PtrW + 1)'(wb_fire_s);
  assign tail_next_s = flush_i ? head_next_s : (tail_r + (PtrW + 1)'(accept_s));

  // Per-unit issue steering and ready selection for the addressed unit.
  always_comb begin
    sel_ready_s     = 1'b0;
    unit_in_valid_o = '0;
    for (int k = 0; k < NumUnits; k++) begin
      unit_in_valid_o[k] = issue_valid_i & ~full_s & ~flush_i & (issue_unit_i == UnitW'(k));
      sel_ready_s        = sel_ready_s | ((issue_unit_i == UnitW'(k)) & unit_in_ready_i[k]);
    end
  end

  // Locate each unit's oldest undone entry and count its undone entries, walking from head.
  always_comb begin
    logic [PtrW-1:0] idx;
    logic            hit;
    idx    = '0;
    hit    = 1'b0;
    pend_s = '0;
    for (int k = 0; k < NumUnits; k++) begin
      target_s[k]     = '0;
      undone_cnt_s[k] = '0;
      for (int j = 0; j < Depth; j++) begin
        idx             = head_idx_s + PtrW'(j);
        hit             = (CntW'(j) < count_s) & ~done_r[idx] & (unit_r[idx] == UnitW'(k));
        undone_cnt_s[k] = undone_cnt_s[k] + CntW'(hit);
        target_s[k]     = (hit & ~pend_s[k]) ? idx : target_s[k];
        pend_s[k]       = pend_s[k] | hit;
      end
    end
  end

  // Result acceptance: results owed to flushed work are drained before live ones.
  always_comb begin
    drop_nz_s        = '0;
    cap_s            = '0;
    drop_s           = '0;
    unit_out_ready_o = '0;
    for (int k = 0; k < NumUnits; k++) begin
      drop_nz_s[k]        = (drop_cnt_r[k] != '0);
      unit_out_ready_o[k] = pend_s[k] | drop_nz_s[k];
      drop_s[k]           = unit_out_valid_i[k] & drop_nz_s[k];
      cap_s[k]            = unit_out_valid_i[k] & pend_s[k] & ~drop_nz_s[k];
      flush_add_s[k]      = flush_i ? (undone_cnt_s[k] - CntW'(cap_s[k])) : '0;
    end
  end

  // Buffer pointers, entry fields and per-unit drop counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_r <= '0;
      tail_r <= '0;
      for (int i = 0; i < Depth; i++) begin
        done_r[i]   <= 1'b0;
        unit_r[i]   <= '0;
        rd_r[i]     <= '0;
        data_r[i]   <= '0;
        status_r[i] <= '0;
      end
      for (int k = 0; k < NumUnits; k++) begin
        drop_cnt_r[k] <= '0;
      end
    end else begin
      head_r <= head_next_s;
      tail_r <= tail_next_s;
      if (accept_s) begin
        unit_r[tail_idx_s] <= issue_unit_i;
        rd_r[tail_idx_s]   <= issue_rd_i;
        done_r[tail_idx_s] <= 1'b0;
      end
      for (int k = 0; k < NumUnits; k++) begin
        if (cap_s[k]) begin
          data_r[target_s[k]]   <= unit_result_i[k*DataWidth +: DataWidth];
          status_r[target_s[k]] <= unit_status_i[k*StatusWidth +: StatusWidth];
          done_r[target_s[k]]   <= 1'b1;
        end
        drop_cnt_r[k] <= drop_cnt_r[k] - CntW'(drop_s[k]) + flush_add_s[k];
      end
      if (wb_fire_s) begin
        done_r[head_idx_s] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cve2_ex_result_sequencer.sv
// Directed bench for cve2_ex_result_sequencer: issue, out-of-order completion,
// full stall, writeback backpressure, flush draining and asynchronous reset.
module tb_cve2_ex_result_sequencer;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_unit;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [2:0]  unit_in_valid;
  logic [2:0]  unit_in_ready;
  logic [2:0]  unit_out_valid;
  logic [2:0]  unit_out_ready;
  logic [95:0] unit_result;
  logic [14:0] unit_status;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  wb_status;
  logic        busy;
  logic [2:0]  outstanding;

  int total_cnt;
  int bad_cnt;

  cve2_ex_result_sequencer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_unit_i     (issue_unit),
    .issue_rd_i       (issue_rd),
    .flush_i          (flush),
    .unit_in_valid_o  (unit_in_valid),
    .unit_in_ready_i  (unit_in_ready),
    .unit_out_valid_i (unit_out_valid),
    .unit_out_ready_o (unit_out_ready),
    .unit_result_i    (unit_result),
    .unit_status_i    (unit_status),
    .wb_valid_o       (wb_valid),
    .wb_ready_i       (wb_ready),
    .wb_rd_o          (wb_rd),
    .wb_data_o        (wb_data),
    .wb_status_o      (wb_status),
    .busy_o           (busy),
    .outstanding_o    (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input int u, input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_unit  = u[1:0];
    issue_rd    = rd;
    #1;
    check_val("issue_ready", issue_ready, 1'b1);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic ret(input int u, input logic [31:0] d, input logic [4:0] st);
    unit_out_valid             = 3'b000;
    unit_out_valid[u]          = 1'b1;
    unit_result[u*32 +: 32]    = d;
    unit_status[u*5 +: 5]      = st;
    tick();
    unit_out_valid = 3'b000;
  endtask

  initial begin
    total_cnt      = 0;
    bad_cnt        = 0;
    rst            = 1'b1;
    issue_valid    = 1'b0;
    issue_unit     = 2'd0;
    issue_rd       = 5'd0;
    flush          = 1'b0;
    unit_in_ready  = 3'b111;
    unit_out_valid = 3'b000;
    unit_result    = 96'd0;
    unit_status    = 15'd0;
    wb_ready       = 1'b0;

    // Reset state
    #2;
    check_val("rst_wb_valid", wb_valid, 1'b0);
    check_val("rst_wb_rd", wb_rd, 5'd0);
    check_val("rst_wb_data", wb_data, 32'd0);
    check_val("rst_wb_status", wb_status, 5'd0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_outstanding", outstanding, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Out-of-range unit index is never accepted
    issue_valid = 1'b1;
    issue_unit  = 2'd3;
    #1;
    check_val("oor_ready", issue_ready, 1'b0);
    check_val("oor_in_valid", unit_in_valid, 3'b000);
    issue_valid = 1'b0;
    tick();

    // Single op on unit1
    issue_valid = 1'b1;
    issue_unit  = 2'd1;
    issue_rd    = 5'd7;
    #1;
    check_val("s_in_valid", unit_in_valid, 3'b010);
    issue_op(1, 5'd7);
    check_val("s_outstanding", outstanding, 3'd1);
    check_val("s_busy", busy, 1'b1);
    check_val("s_out_ready", unit_out_ready, 3'b010);
    tick();
    tick();
    unit_out_valid = 3'b010;
    unit_result[63:32] = 32'hDEADBEEF;
    unit_status[9:5]   = 5'h03;
    #1;
    check_val("s_no_early_wb", wb_valid, 1'b0);
    tick();
    unit_out_valid = 3'b000;
    check_val("s_wb_valid", wb_valid, 1'b1);
    check_val("s_wb_rd", wb_rd, 5'd7);
    check_val("s_wb_data", wb_data, 32'hDEADBEEF);
    check_val("s_wb_status", wb_status, 5'h03);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check_val("s_done_out", outstanding, 3'd0);
    check_val("s_done_busy", busy, 1'b0);
    check_val("s_done_wb", wb_valid, 1'b0);

    // Out-of-order completion between units
    issue_op(0, 5'd1);
    issue_op(2, 5'd2);
    ret(2, 32'h0000_0022, 5'h00);
    check_val("o_held_wb", wb_valid, 1'b0);
    check_val("o_outstanding", outstanding, 3'd2);
    ret(0, 32'h0000_0011, 5'h01);
    check_val("o_wb1_valid", wb_valid, 1'b1);
    check_val("o_wb1_rd", wb_rd, 5'd1);
    check_val("o_wb1_data", wb_data, 32'h11);
    wb_ready = 1'b1;
    tick();
    check_val("o_wb2_valid", wb_valid, 1'b1);
    check_val("o_wb2_rd", wb_rd, 5'd2);
    check_val("o_wb2_data", wb_data, 32'h22);
    tick();
    wb_ready = 1'b0;
    check_val("o_empty", outstanding, 3'd0);

    // Full buffer stalls issue without pop pass-through
    for (int i = 0; i < 4; i++) begin
      issue_op(1, 5'(10 + i));
    end
    issue_valid = 1'b1;
    issue_unit  = 2'd1;
    issue_rd    = 5'd14;
    #1;
    check_val("f_ready", issue_ready, 1'b0);
    check_val("f_in_valid", unit_in_valid, 3'b000);
    check_val("f_outstanding", outstanding, 3'd4);
    issue_valid = 1'b0;
    ret(1, 32'h100, 5'h00);
    wb_ready = 1'b1;
    #1;
    check_val("f_no_passthru", issue_ready, 1'b0);
    tick();
    wb_ready = 1'b0;
    check_val("f_after_pop_out", outstanding, 3'd3);
    check_val("f_after_pop_ready", issue_ready, 1'b1);
    wb_ready = 1'b1;
    ret(1, 32'h101, 5'h00);
    ret(1, 32'h102, 5'h00);
    ret(1, 32'h103, 5'h00);
    check_val("f_last_rd", wb_rd, 5'd13);
    check_val("f_last_data", wb_data, 32'h103);
    tick();
    wb_ready = 1'b0;
    check_val("f_drained", outstanding, 3'd0);

    // Writeback backpressure
    issue_op(2, 5'd9);
    issue_op(2, 5'd4);
    ret(2, 32'hCAFE0001, 5'h11);
    ret(2, 32'hCAFE0002, 5'h12);
    for (int c = 0; c < 3; c++) begin
      check_val("b_valid", wb_valid, 1'b1);
      check_val("b_rd", wb_rd, 5'd9);
      check_val("b_data", wb_data, 32'hCAFE0001);
      check_val("b_status", wb_status, 5'h11);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check_val("b_one_retired", outstanding, 3'd1);
    check_val("b_next_rd", wb_rd, 5'd4);
    check_val("b_next_data", wb_data, 32'hCAFE0002);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check_val("b_empty", outstanding, 3'd0);

    // Flush with three undone unit0 ops
    issue_op(0, 5'd20);
    issue_op(0, 5'd21);
    issue_op(0, 5'd22);
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_unit  = 2'd1;
    #1;
    check_val("x_issue_blocked", issue_ready, 1'b0);
    check_val("x_in_valid", unit_in_valid, 3'b000);
    tick();
    flush       = 1'b0;
    issue_valid = 1'b0;
    check_val("x_outstanding", outstanding, 3'd0);
    check_val("x_busy", busy, 1'b1);
    check_val("x_drop_ready", unit_out_ready, 3'b001);
    ret(0, 32'h1, 5'h00);
    check_val("x_wb1", wb_valid, 1'b0);
    ret(0, 32'h2, 5'h00);
    check_val("x_busy2", busy, 1'b1);
    ret(0, 32'h3, 5'h00);
    check_val("x_wb3", wb_valid, 1'b0);
    check_val("x_idle", busy, 1'b0);
    check_val("x_idle_ready", unit_out_ready, 3'b000);

    // Flush with a same-cycle capture: that result is not owed to the drop counter
    issue_op(0, 5'd23);
    issue_op(0, 5'd24);
    flush = 1'b1;
    ret(0, 32'h5, 5'h00);
    flush = 1'b0;
    check_val("xc_busy", busy, 1'b1);
    check_val("xc_wb", wb_valid, 1'b0);
    ret(0, 32'h6, 5'h00);
    check_val("xc_idle", busy, 1'b0);

    // Flush while the done head retires: only the undone entry is owed
    issue_op(1, 5'd5);
    issue_op(1, 5'd6);
    ret(1, 32'h55, 5'h00);
    check_val("xr_wb_valid", wb_valid, 1'b1);
    wb_ready = 1'b1;
    flush    = 1'b1;
    tick();
    wb_ready = 1'b0;
    flush    = 1'b0;
    check_val("xr_outstanding", outstanding, 3'd0);
    check_val("xr_busy", busy, 1'b1);
    ret(1, 32'h66, 5'h00);
    check_val("xr_idle", busy, 1'b0);

    // Asynchronous reset mid-run
    issue_op(0, 5'd3);
    issue_op(0, 5'd8);
    ret(0, 32'hA, 5'h00);
    ret(0, 32'hB, 5'h00);
    check_val("r_pre_wb", wb_valid, 1'b1);
    check_val("r_pre_out", outstanding, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    check_val("r_wb_valid", wb_valid, 1'b0);
    check_val("r_outstanding", outstanding, 3'd0);
    check_val("r_busy", busy, 1'b0);
    check_val("r_wb_data", wb_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ret(0, 32'hC, 5'h00);
    check_val("r_post_busy", busy, 1'b0);
    check_val("r_post_wb", wb_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/cve2_ex_result_sequencer.md
Name: cve2_ex_result_sequencer

Overview:
Parametrised execution-stage sequencer that issues operations to NumUnits multi-cycle functional units (multdiv, FPU, future accelerators) over valid/ready handshakes. It tracks up to Depth outstanding operations in an in-order completion buffer. Units may finish out of order relative to each other. Results are written back strictly in issue order, and it supports flushing in-flight work.

Parameters:
NumUnits, 3, number of attached functional units (1..8)
DataWidth, 32, result width
Depth, 4, completion-buffer entries (power of two, >=2)
TagWidth, 5, destination register index width
StatusWidth, 5, per-result status flag width (fpnew_pkg::status_t packed = 5)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
issue_valid_i  in  1  operation presented for issue
issue_ready_o  out  1  operation accepted when both valid and ready are high
issue_unit_i  in  $clog2(NumUnits) (min 1)  target unit index
issue_rd_i  in  TagWidth  destination register
flush_i  in  1  discard all in-flight operations
unit_in_valid_o  out  NumUnits  per-unit issue valid
unit_in_ready_i  in  NumUnits  per-unit issue ready
unit_out_valid_i  in  NumUnits  per-unit result valid
unit_out_ready_o  out  NumUnits  per-unit result ready
unit_result_i  in  NumUnits*DataWidth  unit k result in slice [k*DataWidth +: DataWidth]
unit_status_i  in  NumUnits*StatusWidth  unit k status, sliced the same way
wb_valid_o  out  1  in-order writeback valid
wb_ready_i  in  1  writeback consumer ready
wb_rd_o  out  TagWidth  writeback destination
wb_data_o  out  DataWidth  writeback data
wb_status_o  out  StatusWidth  writeback status
busy_o  out  1  any live or draining operation
outstanding_o  out  $clog2(Depth+1)  live buffer occupancy

Behaviour:
- Reset (rst_i high, async): buffer empty, head=tail=0, all done flags and drop counters cleared. Outputs while in reset: wb_valid_o=0, wb_rd_o=0, wb_data_o=0, wb_status_o=0, busy_o=0, outstanding_o=0. Reset mid-operation discards everything; unit results arriving after reset are not tracked.
- Issue:
  - issue_ready_o = ~full & ~flush_i & (issue_unit_i<NumUnits) & unit_in_ready_i[issue_unit_i].
  - unit_in_valid_o[k] = issue_valid_i & ~full & ~flush_i & (issue_unit_i==k).
  - Out-of-range unit index: never accepted.
  - On acceptance, {unit, rd, done=0} is pushed at tail. When full, issue stalls with no same-cycle pop pass-through.
- Result capture:
  - Each unit returns results in its own issue order. unit_out_ready_o[k]=1 when unit k has a live undone entry or drop_cnt[k]!=0.
  - On unit_out_valid_i[k] & unit_out_ready_o[k]:
    - If drop_cnt[k]!=0, decrement it and discard the result.
    - Otherwise write data/status into the oldest live undone entry with unit==k (searched from head) and set its done flag.
  - Multiple units may complete in the same cycle; all captures occur.
- Writeback:
  - wb_valid_o = head entry live & done, driven from registers. Minimum latency is issue accept N -> result at N+L -> wb_valid_o at N+L+1.
  - wb_* hold stable while wb_valid_o & ~wb_ready_i.
  - On handshake, pop the head; the next entry may present in the following cycle.
- Flush:
  - A same-cycle writeback handshake still retires normally.
  - All other entries are invalidated.
  - For every unit k, drop_cnt[k] += number of invalidated undone entries of unit k, excluding any entry captured in that same cycle. That captured result is itself discarded.
  - Issue is blocked during the flush cycle; the next cycle is a normal idle cycle.
- Counters:
  - Pointers wrap modulo Depth; full/empty use an extra wrap bit.
  - outstanding_o = tail-head over live entries.
  - drop_cnt width is $clog2(Depth+1) and never exceeds Depth.
- busy_o = (outstanding_o!=0) | (any drop_cnt!=0).

Test Plan:
- Single op: issue unit1 rd=7, unit returns 0xDEADBEEF 3 cycles later -> wb_valid_o one cycle after capture, rd=7, data=0xDEADBEEF, outstanding_o returns 0.
- Out-of-order units: issue unit0 rd=1 (latency 5), then unit2 rd=2 (latency 1) -> unit2 result buffered; writeback order rd=1 then rd=2.
- Full: issue 4 ops with no results -> issue_ready_o=0 and outstanding_o=4. One writeback with wb_ready_i=1 -> issue_ready_o=1 next cycle.
- Backpressure: done head, wb_ready_i=0 for 3 cycles -> wb_* stable; handshake on cycle 4 retires exactly one entry.
- Flush: 3 live undone ops on unit0, flush_i pulsed -> outstanding_o=0, busy_o=1. Three later unit0 results are accepted and dropped, then busy_o=0, and no wb_valid_o occurs.
- Reset mid-run: 2 entries live with wb_valid_o=1, assert rst_i asynchronously -> wb_valid_o=0, outstanding_o=0, busy_o=0 immediately.
